// File: rtl/key_event_pkg.sv
// Shared types and default timing for the push-button event front-end.
// Channel state encoding and a constant helper for sizing the down-counter.
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } key_state_t;

    // 50 MHz board clock: 20 ms debounce, 0.5 s first repeat, 0.1 s repeat rate
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// inc/dec event interface between the button front-end and its consumer.
// inc/dec are single-cycle strobes: no ready, the consumer must act in that cycle.
interface key_event_gen_if;
    logic inc;
    logic dec;
    logic held_inc;
    logic held_dec;

    modport master (output inc, output dec, output held_inc, output held_dec);
    modport slave  (input  inc, input  dec, input  held_inc, input  held_dec);
endinterface

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchronizer, debounce / hold / auto-repeat FSM
// sharing a single down-counter; pulse is registered, held decodes the state.
module key_channel
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = 1
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       key_n,
    output logic       pulse,
    output logic       held,
    output key_state_t state
);

    localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             pressed;
    logic             expired;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_d;

    assign pressed = ~sync_q[1];
    assign expired = (cnt_q == '0);

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
        end
    end

    // A release seen in the same cycle as a repeat expiry wins: no pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = DEB_PRESS;
                    cnt_d   = DEB_LOAD;
                end
            end
            DEB_PRESS: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (expired) begin
                    state_d = HELD;
                    cnt_d   = DLY_LOAD;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HELD, REPEAT: begin
                if (!pressed) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = DEB_LOAD;
                end else if (expired) begin
                    state_d = REPEAT;
                    cnt_d   = PER_LOAD;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DEB_RELEASE: begin
                if (pressed) begin
                    cnt_d = DEB_LOAD;
                end else if (expired) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign held  = (state_q == HELD) || (state_q == REPEAT) || (state_q == DEB_RELEASE);
    assign state = state_q;

endmodule

// File: rtl/key_event_gen.sv
// Debounced inc/dec event generator with hold-to-repeat for the DE1 counter demo.
// Holding one key suppresses events from the other; outputs are registered.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                   clock_50,
    input  logic                   reset_n,
    input  logic                   key_inc_n,
    input  logic                   key_dec_n,
    key_event_gen_if.master        evt,
    output key_state_t             dbg_state_inc,
    output key_state_t             dbg_state_dec
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_event_gen: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 2) begin : g_bad_delay
        $error("key_event_gen: REPEAT_DELAY must be >= 2");
    end
    if (REPEAT_PERIOD < 2) begin : g_bad_period
        $error("key_event_gen: REPEAT_PERIOD must be >= 2");
    end

    logic pulse_inc, pulse_dec;
    logic held_inc_ch, held_dec_ch;

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .CNT_W          (CNT_W)
    ) u_inc (
        .clock_50(clock_50),
        .reset_n (reset_n),
        .key_n   (key_inc_n),
        .pulse   (pulse_inc),
        .held    (held_inc_ch),
        .state   (dbg_state_inc)
    );

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .CNT_W          (CNT_W)
    ) u_dec (
        .clock_50(clock_50),
        .reset_n (reset_n),
        .key_n   (key_dec_n),
        .pulse   (pulse_dec),
        .held    (held_dec_ch),
        .state   (dbg_state_dec)
    );

    // A channel pulse implies its own held, so inc and dec can never coincide.
    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            evt.inc      <= 1'b0;
            evt.dec      <= 1'b0;
            evt.held_inc <= 1'b0;
            evt.held_dec <= 1'b0;
        end else begin
            evt.inc      <= pulse_inc & ~held_dec_ch;
            evt.dec      <= pulse_dec & ~held_inc_ch;
            evt.held_inc <= held_inc_ch;
            evt.held_dec <= held_dec_ch;
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen with short timing parameters.
// Reference model works from run lengths of the synced key and absolute fire times.
module tb_key_event_gen;
    import key_event_pkg::*;

    localparam int DEB  = 4;
    localparam int RDLY = 10;
    localparam int RPER = 3;
    localparam int W    = 8;

    logic       clock_50;
    logic       reset_n;
    logic       key_inc_n;
    logic       key_dec_n;
    key_state_t dbg_state_inc;
    key_state_t dbg_state_dec;

    key_event_gen_if evt();

    key_event_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clock_50     (clock_50),
        .reset_n      (reset_n),
        .key_inc_n    (key_inc_n),
        .key_dec_n    (key_dec_n),
        .evt          (evt),
        .dbg_state_inc(dbg_state_inc),
        .dbg_state_dec(dbg_state_dec)
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state, index 0 = inc key, 1 = dec key
    bit   d1[2], d2[2];
    bit   m_held[2], m_rel[2], m_pulse[2];
    int   press_run[2], rel_run[2], rel_need[2], next_fire[2];
    int   tcyc = 0;
    logic [3:0] exp_out = 4'b0;

    task automatic model_step();
        bit pin[2];
        bit pr;
        pin[0] = key_inc_n;
        pin[1] = key_dec_n;
        if (!reset_n) begin
            exp_out = 4'b0;
            for (int k = 0; k < 2; k++) begin
                d1[k] = 1'b1; d2[k] = 1'b1;
                m_held[k] = 1'b0; m_rel[k] = 1'b0; m_pulse[k] = 1'b0;
                press_run[k] = 0; rel_run[k] = 0; rel_need[k] = 0; next_fire[k] = 0;
            end
        end else begin
            exp_out = {m_pulse[0] & ~m_held[1], m_pulse[1] & ~m_held[0], m_held[0], m_held[1]};
            for (int k = 0; k < 2; k++) begin
                pr = ~d2[k];
                d2[k] = d1[k];
                d1[k] = pin[k];
                m_pulse[k] = 1'b0;
                if (!m_held[k]) begin
                    press_run[k] = pr ? press_run[k] + 1 : 0;
                    if (press_run[k] == DEB + 1) begin
                        m_held[k] = 1'b1; m_rel[k] = 1'b0; m_pulse[k] = 1'b1;
                        next_fire[k] = tcyc + RDLY;
                        press_run[k] = 0;
                    end
                end else if (!m_rel[k]) begin
                    if (!pr) begin
                        m_rel[k] = 1'b1; rel_run[k] = 1; rel_need[k] = DEB + 1;
                    end else if (tcyc == next_fire[k]) begin
                        m_pulse[k] = 1'b1;
                        next_fire[k] = tcyc + RPER;
                    end
                end else begin
                    if (pr) begin
                        rel_run[k] = 0; rel_need[k] = DEB;
                    end else begin
                        rel_run[k] = rel_run[k] + 1;
                    end
                    if (rel_run[k] == rel_need[k]) m_held[k] = 1'b0;
                end
            end
        end
        tcyc++;
    endtask

    task automatic tick();
        @(posedge clock_50);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int e = 0; e < 5; e++) begin
            key_inc_n = 1'($urandom_range(0, 1));
            key_dec_n = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs edge %0d got %b expected 0000", e,
                         {evt.inc, evt.dec, evt.held_inc, evt.held_dec});
            end
        end
        reset_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            checks++;
            if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_outputs edge %0d got %b expected 0000", e,
                         {evt.inc, evt.dec, evt.held_inc, evt.held_dec});
            end
        end
        checks++;
        if (dbg_state_inc !== IDLE || dbg_state_dec !== IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d/%0d expected IDLE", dbg_state_inc, dbg_state_dec);
        end
    endtask

    task automatic test_single_press();
        int n = 0;
        int first = -1;
        for (int e = 0; e < 24; e++) begin
            key_inc_n = (e < 8) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== exp_out) begin
                errors++;
                $display("FAIL single_press edge %0d got %b expected %b", e,
                         {evt.inc, evt.dec, evt.held_inc, evt.held_dec}, exp_out);
            end
            if (evt.inc) begin
                n++;
                if (first < 0) first = e;
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL single_press_count got %0d expected 1", n);
        end
        checks++;
        if (first != 7) begin
            errors++;
            $display("FAIL single_press_edge got %0d expected 7", first);
        end
    endtask

    task automatic test_bounce();
        int n = 0;
        int first = -1;
        for (int e = 0; e < 40; e++) begin
            key_inc_n = (e < 3 || (e >= 5 && e < 17) || (e >= 19 && e < 25)) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== exp_out) begin
                errors++;
                $display("FAIL bounce edge %0d got %b expected %b", e,
                         {evt.inc, evt.dec, evt.held_inc, evt.held_dec}, exp_out);
            end
            if (evt.inc) begin
                n++;
                if (first < 0) first = e;
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL bounce_count got %0d expected 1", n);
        end
        checks++;
        if (first != 12) begin
            errors++;
            $display("FAIL bounce_edge got %0d expected 12", first);
        end
    endtask

    task automatic test_repeat();
        logic [W-1:0] want;
        exp_q = {8'd7, 8'd17, 8'd20, 8'd23, 8'd26, 8'd29};
        for (int e = 0; e < 44; e++) begin
            key_dec_n = (e < 30) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== exp_out) begin
                errors++;
                $display("FAIL repeat edge %0d got %b expected %b", e,
                         {evt.inc, evt.dec, evt.held_inc, evt.held_dec}, exp_out);
            end
            checks++;
            if (evt.inc !== 1'b0) begin
                errors++;
                $display("FAIL repeat_no_inc edge %0d got %b expected 0", e, evt.inc);
            end
            if (evt.dec && e < 30) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hff;
                checks++;
                if (8'(e) !== want) begin
                    errors++;
                    $display("FAIL repeat_edge got %0d expected %0d", e, want);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL repeat_missing got %0d pulses left expected 0", exp_q.size());
        end
    endtask

    task automatic test_both_keys();
        int n_dec = 0;
        int n_inc_early = 0;
        int first = -1;
        for (int e = 0; e < 54; e++) begin
            key_dec_n = (e < 20) ? 1'b0 : 1'b1;
            key_inc_n = (e < 40) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== exp_out) begin
                errors++;
                $display("FAIL both_keys edge %0d got %b expected %b", e,
                         {evt.inc, evt.dec, evt.held_inc, evt.held_dec}, exp_out);
            end
            if (e == 19) begin
                checks++;
                if ({evt.held_inc, evt.held_dec} !== 2'b11) begin
                    errors++;
                    $display("FAIL both_held got %b expected 11", {evt.held_inc, evt.held_dec});
                end
            end
            if (evt.dec) n_dec++;
            if (evt.inc && e <= 20) n_inc_early++;
            if (evt.inc && e > 20 && first < 0) first = e;
        end
        checks++;
        if (n_dec != 0 || n_inc_early != 0) begin
            errors++;
            $display("FAIL both_blocked got dec %0d inc %0d expected 0 0", n_dec, n_inc_early);
        end
        checks++;
        if (first != 29) begin
            errors++;
            $display("FAIL both_resume_edge got %0d expected 29", first);
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [W-1:0] want;
        exp_q = {8'd7, 8'd17, 8'd26, 8'd36};
        for (int e = 0; e < 50; e++) begin
            key_inc_n = (e < 36) ? 1'b0 : 1'b1;
            reset_n   = (e == 18) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== exp_out) begin
                errors++;
                $display("FAIL reset_mid edge %0d got %b expected %b", e,
                         {evt.inc, evt.dec, evt.held_inc, evt.held_dec}, exp_out);
            end
            if (e == 18) begin
                checks++;
                if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== 4'b0000) begin
                    errors++;
                    $display("FAIL reset_mid_clear got %b expected 0000",
                             {evt.inc, evt.dec, evt.held_inc, evt.held_dec});
                end
            end
            if (evt.inc) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hff;
                checks++;
                if (8'(e) !== want) begin
                    errors++;
                    $display("FAIL reset_mid_pulse got %0d expected %0d", e, want);
                end
            end
        end
        reset_n = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_missing got %0d pulses left expected 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        int run_i = 0;
        int run_d = 0;
        for (int e = 0; e < 700; e++) begin
            if (e < 680) begin
                if (run_i == 0) begin
                    key_inc_n = ~key_inc_n;
                    run_i = $urandom_range(1, 14);
                end
                if (run_d == 0) begin
                    key_dec_n = ~key_dec_n;
                    run_d = $urandom_range(1, 14);
                end
                run_i--;
                run_d--;
                reset_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            end else begin
                key_inc_n = 1'b1; key_dec_n = 1'b1; reset_n = 1'b1;
            end
            tick();
            checks++;
            if ({evt.inc, evt.dec, evt.held_inc, evt.held_dec} !== exp_out) begin
                errors++;
                $display("FAIL random edge %0d got %b expected %b", e,
                         {evt.inc, evt.dec, evt.held_inc, evt.held_dec}, exp_out);
            end
            checks++;
            if (evt.inc === 1'b1 && evt.dec === 1'b1) begin
                errors++;
                $display("FAIL random_exclusive edge %0d got inc 1 dec 1 expected not both", e);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        test_both_keys();
        test_reset_mid_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
